// File: rtl/wb_pipelined_mux_if.sv
// Signal bundle for the 1-to-Count pipelined Wishbone interconnect: the upstream
// master link plus every slave link, per-slave fields packed by slave index.
interface wb_pipelined_mux_if #(
    parameter int Count     = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    localparam int SelWidth = DataWidth / 8;

    logic [DataWidth-1:0]            m_data_m;
    logic [AddrWidth-1:0]            m_addr;
    logic [SelWidth-1:0]             m_sel;
    logic                            m_cyc;
    logic                            m_stb;
    logic                            m_we;
    logic [DataWidth-1:0]            m_data_s;
    logic                            m_ack;
    logic                            m_err;
    logic                            m_stall;

    logic [Count-1:0][DataWidth-1:0] s_data_s;
    logic [Count-1:0]                s_ack;
    logic [Count-1:0]                s_err;
    logic [Count-1:0]                s_stall;
    logic [Count-1:0][DataWidth-1:0] s_data_m;
    logic [Count-1:0][AddrWidth-1:0] s_addr;
    logic [Count-1:0][SelWidth-1:0]  s_sel;
    logic [Count-1:0]                s_cyc;
    logic [Count-1:0]                s_stb;
    logic [Count-1:0]                s_we;

    // Environment view: the upstream master together with the attached slaves.
    modport master (
        output m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
        input  m_data_s, m_ack, m_err, m_stall,
        output s_data_s, s_ack, s_err, s_stall,
        input  s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we
    );

    // Interconnect view.
    modport slave (
        input  m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
        output m_data_s, m_ack, m_err, m_stall,
        input  s_data_s, s_ack, s_err, s_stall,
        output s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we
    );
endinterface

// File: rtl/wb_pipelined_mux.sv
// 1-to-Count pipelined Wishbone interconnect: address decode, outstanding-request
// tracking per target, internal error responder for unmapped space and a watchdog.
module wb_pipelined_mux #(
    parameter int Count          = 4,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int DecodeLsb      = 28,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    wb_pipelined_mux_if.slave  bus
);
    localparam int TagWidth   = (Count > 1) ? $clog2(Count) : 1;
    localparam int SlotCount  = 1 << TagWidth;
    localparam int CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0]   CntFull   = CntWidth'(MaxOutstanding);
    localparam logic [TimerWidth-1:0] TimerLast =
        (TimeoutCycles > 0) ? TimerWidth'(TimeoutCycles - 1) : '0;

    logic [TagWidth-1:0]                 req_tag_s;
    logic                                req_mapped_s;
    logic                                req_valid_s;
    logic [AddrWidth-1:0]                addr_masked_s;
    logic [TagWidth-1:0]                 active_tag_r;
    logic                                active_unmapped_r;
    logic [CntWidth-1:0]                 cnt_r;
    logic [TimerWidth-1:0]               timer_r;
    logic                                busy_s;
    logic                                blocked_s;
    logic                                stall_s;
    logic                                accept_s;
    logic                                resp_s;
    logic                                timeout_fire_s;
    logic                                head_ack_s;
    logic                                head_err_s;
    logic [SlotCount-1:0]                ack_pad_s;
    logic [SlotCount-1:0]                err_pad_s;
    logic [SlotCount-1:0]                stall_pad_s;
    logic [SlotCount-1:0][DataWidth-1:0] data_pad_s;

    assign req_tag_s    = bus.m_addr[DecodeLsb +: TagWidth];
    assign req_mapped_s = (int'(req_tag_s) < Count);
    assign req_valid_s  = bus.m_cyc & bus.m_stb;
    assign busy_s       = (cnt_r != '0);

    // Slave responses widened to every tag value so unmapped tags read as silent.
    always_comb begin
        ack_pad_s   = '0;
        err_pad_s   = '0;
        stall_pad_s = '0;
        data_pad_s  = '0;
        for (int i = 0; i < Count; i++) begin
            ack_pad_s[i]   = bus.s_ack[i];
            err_pad_s[i]   = bus.s_err[i];
            stall_pad_s[i] = bus.s_stall[i];
            data_pad_s[i]  = bus.s_data_s[i];
        end
    end

    // Slave address with the select field cleared.
    always_comb begin
        addr_masked_s = bus.m_addr;
        addr_masked_s[DecodeLsb +: TagWidth] = '0;
    end

    assign head_ack_s = ack_pad_s[active_tag_r];
    assign head_err_s = err_pad_s[active_tag_r];

    // The internal responder answers one unmapped request every cycle.
    assign resp_s = bus.m_cyc & busy_s & (active_unmapped_r | head_ack_s | head_err_s);

    assign timeout_fire_s = (TimeoutCycles != 0) & (timer_r == TimerLast) & busy_s & ~resp_s;

    // A new request may only join outstanding ones that target the same place.
    assign blocked_s = (cnt_r == CntFull)
                     | (busy_s & ((req_tag_s != active_tag_r) | (~req_mapped_s != active_unmapped_r)))
                     | timeout_fire_s;

    assign stall_s  = req_valid_s & (blocked_s | (req_mapped_s & stall_pad_s[req_tag_s]));
    assign accept_s = req_valid_s & ~stall_s;

    assign bus.m_stall  = stall_s;
    assign bus.m_ack    = bus.m_cyc & busy_s & ~active_unmapped_r & head_ack_s & ~head_err_s;
    assign bus.m_err    = bus.m_cyc & ((busy_s & (active_unmapped_r | head_err_s)) | timeout_fire_s);
    assign bus.m_data_s = (bus.m_cyc & busy_s & ~active_unmapped_r) ? data_pad_s[active_tag_r] : '0;

    // Per-slave fan-out: broadcast payload, decoded strobe, held cycle.
    always_comb begin
        bus.s_data_m = '0;
        bus.s_addr   = '0;
        bus.s_sel    = '0;
        bus.s_we     = '0;
        bus.s_stb    = '0;
        bus.s_cyc    = '0;
        for (int i = 0; i < Count; i++) begin
            bus.s_data_m[i] = bus.m_data_m;
            bus.s_addr[i]   = addr_masked_s;
            bus.s_sel[i]    = bus.m_sel;
            bus.s_we[i]     = bus.m_we;
            bus.s_stb[i]    = req_valid_s & req_mapped_s & (int'(req_tag_s) == i) & ~blocked_s;
            bus.s_cyc[i]    = reset_n & bus.m_cyc & ~timeout_fire_s &
                              (busy_s ? ((int'(active_tag_r) == i) & ~active_unmapped_r)
                                      : (req_mapped_s & (int'(req_tag_s) == i)));
        end
    end

    // Outstanding count, active target and watchdog timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r             <= '0;
            timer_r           <= '0;
            active_tag_r      <= '0;
            active_unmapped_r <= 1'b0;
        end else if (!bus.m_cyc || timeout_fire_s) begin
            cnt_r   <= '0;
            timer_r <= '0;
        end else begin
            cnt_r <= cnt_r + CntWidth'(accept_s) - CntWidth'(resp_s);
            if (busy_s && !resp_s && (TimeoutCycles != 0)) begin
                timer_r <= timer_r + TimerWidth'(1);
            end else begin
                timer_r <= '0;
            end
            if (accept_s) begin
                active_tag_r      <= req_tag_s;
                active_unmapped_r <= ~req_mapped_s;
            end
        end
    end
endmodule

// File: tb/tb_wb_pipelined_mux.sv
// Directed bench for wb_pipelined_mux with a queue-based reference model checked
// every cycle, plus hand-computed expectations at the interesting cycles.
module tb_wb_pipelined_mux;
    localparam int Count   = 3;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int MaxOut  = 2;
    localparam int Timeout = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_pipelined_mux_if #(.Count(Count), .DataWidth(DW), .AddrWidth(AW)) bus ();

    wb_pipelined_mux #(
        .Count(Count), .DataWidth(DW), .AddrWidth(AW), .DecodeLsb(28),
        .MaxOutstanding(MaxOut), .TimeoutCycles(Timeout)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int errors   = 0;
    int checks   = 0;
    int ack_seen = 0;
    int q[$];
    int quiet    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of targets of outstanding requests, -1 meaning the error responder.
    always @(negedge clk) begin
        int tag, cls, head;
        bit busy, mapped, hack, herr, resp, fire, blocked, acc;
        logic [Count-1:0] e_stb, e_cyc;
        logic [DW-1:0] e_data;
        logic e_ack, e_err, e_stall;
        if (!reset_n) begin
            q.delete();
            quiet = 0;
            check("rst_idle", {bus.m_ack, bus.m_err, bus.s_cyc, bus.s_stb}, 128'd0);
        end else begin
            tag    = int'(bus.m_addr[29:28]);
            mapped = (tag < Count);
            cls    = mapped ? tag : -1;
            busy   = (q.size() != 0);
            head   = busy ? q[0] : -2;
            hack   = (head >= 0) ? bus.s_ack[head] : 1'b0;
            herr   = (head >= 0) ? bus.s_err[head] : 1'b0;
            resp   = bus.m_cyc && busy && (head < 0 || hack || herr);
            fire   = busy && !resp && (quiet == Timeout - 1);
            blocked = (q.size() == MaxOut) || (busy && cls != head) || fire;
            e_stall = bus.m_cyc && bus.m_stb && (blocked || (mapped && bus.s_stall[tag]));
            for (int i = 0; i < Count; i++) begin
                e_stb[i] = bus.m_cyc && bus.m_stb && mapped && tag == i && !blocked;
                e_cyc[i] = bus.m_cyc && !fire && (busy ? head == i : cls == i);
            end
            e_ack  = bus.m_cyc && busy && head >= 0 && hack && !herr;
            e_err  = bus.m_cyc && ((busy && (head < 0 || herr)) || fire);
            e_data = (bus.m_cyc && busy && head >= 0) ? bus.s_data_s[head] : 32'h0;
            check("m_ack",    bus.m_ack,    e_ack);
            check("m_err",    bus.m_err,    e_err);
            check("m_stall",  bus.m_stall,  e_stall);
            check("m_data_s", bus.m_data_s, e_data);
            check("s_stb",    bus.s_stb,    e_stb);
            check("s_cyc",    bus.s_cyc,    e_cyc);
            check("s_addr",   bus.s_addr,   {Count{bus.m_addr & 32'hCFFF_FFFF}});
            check("s_bcast",  {bus.s_data_m, bus.s_sel, bus.s_we},
                              {{Count{bus.m_data_m}}, {Count{bus.m_sel}}, {Count{bus.m_we}}});
            if (bus.m_ack) ack_seen++;
            acc = bus.m_cyc && bus.m_stb && !e_stall;
            if (!bus.m_cyc || fire) begin
                q.delete();
                quiet = 0;
            end else begin
                quiet = (busy && !resp) ? quiet + 1 : 0;
                if (resp) void'(q.pop_front());
                if (acc) q.push_back(cls);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic cyc, input logic stb, input logic we, input logic [31:0] addr);
        bus.m_cyc  = cyc;
        bus.m_stb  = stb;
        bus.m_we   = we;
        bus.m_addr = addr;
    endtask

    task automatic slv(input logic [2:0] ack, input logic [2:0] err, input logic [2:0] stall);
        bus.s_ack   = ack;
        bus.s_err   = err;
        bus.s_stall = stall;
    endtask

    initial begin
        logic [31:0] a;
        req(1'b0, 1'b0, 1'b0, 32'h0);
        slv(3'b000, 3'b000, 3'b000);
        bus.m_data_m = 32'h1234_5678;
        bus.m_sel    = 4'hF;
        bus.s_data_s = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #2 check("reset_idle", {bus.m_ack, bus.m_err, bus.m_stall, bus.s_cyc, bus.s_stb}, 128'd0);

        // Back-to-back reads to slave 1, answered one cycle behind.
        tick(); req(1'b1, 1'b1, 1'b0, 32'h1000_0000);
        #2 check("t1_stb", {bus.m_stall, bus.s_stb}, {1'b0, 3'b010});
        tick(); req(1'b1, 1'b1, 1'b0, 32'h1000_0004); slv(3'b010, 3'b000, 3'b000); bus.s_data_s[1] = 32'h0000_000A;
        #2 check("t1_data_a", {bus.m_stall, bus.m_ack, bus.m_data_s}, {1'b0, 1'b1, 32'h0000_000A});
        tick(); req(1'b1, 1'b1, 1'b0, 32'h1000_0008); bus.s_data_s[1] = 32'h0000_000B;
        #2 check("t1_data_b", {bus.m_stall, bus.m_ack, bus.m_data_s}, {1'b0, 1'b1, 32'h0000_000B});
        tick(); req(1'b1, 1'b0, 1'b0, 32'h1000_0008); bus.s_data_s[1] = 32'h0000_000C;
        #2 check("t1_data_c", {bus.m_ack, bus.m_data_s}, {1'b1, 32'h0000_000C});
        tick(); req(1'b1, 1'b1, 1'b0, 32'h2000_0000); slv(3'b000, 3'b000, 3'b000);
        #2 check("t1_drained", {bus.m_stall, bus.s_stb}, {1'b0, 3'b100});
        tick(); req(1'b1, 1'b0, 1'b0, 32'h2000_0000); slv(3'b100, 3'b000, 3'b000);
        #2 check("t1_s2_ack", bus.m_ack, 1'b1);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);

        // Four reads to slave 0 with two allowed in flight, acks five cycles late.
        ack_seen = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            a = (c == 1) ? 32'h0 : (c == 2) ? 32'h4 : (c <= 7) ? 32'h8 : 32'hC;
            req(1'b1, (c <= 8), 1'b0, a);
            slv((c == 6 || c == 7 || c == 12 || c == 13) ? 3'b001 : 3'b000, 3'b000, 3'b000);
            #2;
            if (c >= 3 && c <= 8) check("t2_stall", bus.m_stall, (c <= 6));
        end
        check("t2_acks", ack_seen, 4);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);

        // Switching target waits for the outstanding response.
        tick(); req(1'b1, 1'b1, 1'b0, 32'h0000_0010);
        for (int c = 2; c <= 4; c++) begin
            tick(); req(1'b1, 1'b1, 1'b0, 32'h2000_0000); slv((c == 4) ? 3'b001 : 3'b000, 3'b000, 3'b000);
            #2 check("t3_blocked", {bus.m_stall, bus.s_stb}, {1'b1, 3'b000});
        end
        tick(); slv(3'b000, 3'b000, 3'b000);
        #2 check("t3_switch", {bus.m_stall, bus.s_stb}, {1'b0, 3'b100});
        tick(); req(1'b1, 1'b0, 1'b0, 32'h2000_0000); slv(3'b100, 3'b000, 3'b000);
        #2 check("t3_s2_ack", bus.m_ack, 1'b1);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);

        // Unmapped write: accepted silently, error one cycle later.
        tick(); req(1'b1, 1'b1, 1'b1, 32'h3000_0000);
        #2 check("t4_accept", {bus.m_stall, bus.s_stb, bus.s_cyc}, 7'b0);
        tick(); req(1'b1, 1'b0, 1'b0, 32'h3000_0000);
        #2 check("t4_err", {bus.m_err, bus.m_ack}, 2'b10);
        tick();
        #2 check("t4_done", {bus.m_err, bus.m_ack}, 2'b00);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0);

        // Watchdog: slave 1 never answers.
        tick(); req(1'b1, 1'b1, 1'b0, 32'h1000_0020);
        for (int c = 2; c <= 9; c++) begin
            tick(); req(1'b1, 1'b0, 1'b0, 32'h1000_0020);
            #2 check("t5_wd", {bus.m_err, bus.s_cyc[1]}, (c == 9) ? 2'b10 : 2'b01);
        end
        tick(); req(1'b1, 1'b1, 1'b0, 32'h2000_0000);
        #2 check("t5_next", {bus.m_stall, bus.s_stb}, {1'b0, 3'b100});
        tick(); req(1'b1, 1'b0, 1'b0, 32'h2000_0000); slv(3'b100, 3'b000, 3'b000);
        #2 check("t5_s2_ack", bus.m_ack, 1'b1);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);

        // Cycle abort drops late responses.
        bus.s_data_s[0] = 32'hDEAD_BEEF;
        tick(); req(1'b1, 1'b1, 1'b0, 32'h0000_0000);
        tick(); req(1'b1, 1'b1, 1'b0, 32'h0000_0004);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0000_0004); slv(3'b001, 3'b000, 3'b000);
        #2 check("t6_abort", {bus.m_ack, bus.m_err, bus.m_data_s}, 34'd0);
        tick(); req(1'b1, 1'b0, 1'b0, 32'h0000_0004);
        #2 check("t6_late", {bus.m_ack, bus.m_err, bus.m_data_s}, 34'd0);
        tick(); req(1'b1, 1'b1, 1'b0, 32'h2000_0000); slv(3'b000, 3'b000, 3'b000);
        #2 check("t6_cnt0", {bus.m_stall, bus.s_stb}, {1'b0, 3'b100});
        tick(); req(1'b1, 1'b0, 1'b0, 32'h2000_0000); slv(3'b100, 3'b000, 3'b000);
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);

        // Asynchronous reset in the middle of a burst.
        tick(); req(1'b1, 1'b1, 1'b0, 32'h0000_0000);
        tick(); req(1'b1, 1'b1, 1'b0, 32'h0000_0004);
        tick(); req(1'b1, 1'b0, 1'b0, 32'h0000_0004); slv(3'b001, 3'b000, 3'b000);
        #1 check("t7_pre_rst", bus.m_ack, 1'b1);
        reset_n = 1'b0;
        #1 check("t7_rst_idle", {bus.m_ack, bus.m_err, bus.m_stall, bus.s_cyc, bus.s_stb}, 9'd0);
        tick(); tick(); reset_n = 1'b1;
        #2 check("t7_after_rst", {bus.m_ack, bus.m_err, bus.s_cyc}, {2'b00, 3'b001});
        tick(); req(1'b0, 1'b0, 1'b0, 32'h0); slv(3'b000, 3'b000, 3'b000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
